// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory with its memory-mapped I/O window:
// word offsets inside the 16-word window, KB_STATUS bit layout, and the
// address-region classification used by the top-level decoder.
package dmem_mmio_pkg;

  // Number of words in the I/O window
  localparam int IO_WORDS = 16;

  // Word offsets inside the I/O window
  localparam logic [3:0] OFF_KB_DATA   = 4'd0;
  localparam logic [3:0] OFF_KB_STATUS = 4'd1;
  localparam logic [3:0] OFF_OUT_BASE  = 4'd2;
  localparam logic [3:0] OFF_CYCLES    = 4'd15;

  // KB_STATUS bit positions; the count field starts at STAT_COUNT_LSB
  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;

  // Writing a 1 to this bit of KB_STATUS clears the sticky overflow flag
  localparam int OVF_CLEAR_BIT = 2;

  // Which part of the word-address space an access falls into
  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_NONE
  } region_e;

endpackage

// File: rtl/dmem_mmio_if.sv
// Processor data-port bus: the single-cycle core drives address, write data,
// byte enables and the write/read strobes; the memory returns read data
// combinationally in the same cycle.
interface dmem_mmio_if #(
  parameter int inputAbits = 32,
  parameter int Dbits      = 32
) ();

  logic                  wr;
  logic                  rd;
  logic [Dbits/8-1:0]    be;
  logic [inputAbits-1:0] addr;
  logic [Dbits-1:0]      din;
  logic [Dbits-1:0]      dout;

  modport master (
    output wr,
    output rd,
    output be,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  wr,
    input  rd,
    input  be,
    input  addr,
    input  din,
    output dout
  );

endinterface

// File: rtl/dmem_mmio_kb_fifo.sv
// Keyboard FIFO: DEPTH entries of W bits with a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the key is dropped and overflow is set. Setting overflow
// wins over a same-cycle clear.
module kb_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  input  logic          ovf_clear,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a key
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Entry storage
  // NOTE: storage has no reset; pointers and count alone say which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and sticky overflow
  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Processor data memory with a 16-word memory-mapped I/O window.
// Word-addressed RAM (byte-enable writes, combinational read) below
// MEM_WORDS; keyboard FIFO, status, NOUT output registers and a free-running
// cycle counter at IO_BASE..IO_BASE+15; everything else reads as zero.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int inputAbits = 32,
  parameter int Abits      = 12,
  parameter int Dbits      = 32,
  parameter int MEM_WORDS  = 1616,
  parameter int IO_BASE    = 4080,
  parameter int KB_DEPTH   = 8,
  parameter int NOUT       = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  dmem_mmio_if.slave            bus,
  input  logic                  kb_valid,
  input  logic [15:0]           kb_char,
  output logic                  kb_nonempty,
  output logic [NOUT*Dbits-1:0] out_regs
);

  localparam int NBYTES = Dbits / 8;
  localparam int CW     = $clog2(KB_DEPTH) + 1;
  localparam int RAM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [Abits-1:0]  w;
  logic [31:0]       w32;
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;
  logic [3:0]        o;
  logic              addr_unused;

  logic              io_wr;
  logic              kb_pop;
  logic              ovf_clear;
  logic [15:0]       kb_head;
  logic [CW-1:0]     kb_count;
  logic              kb_full;
  logic              kb_empty;
  logic              kb_ovf;

  logic [Dbits-1:0]  ram [MEM_WORDS];
  logic [Dbits-1:0]  cycles;
  logic [Dbits-1:0]  status;
  logic [Dbits-1:0]  rdata;

  assign w           = bus.addr[Abits+1:2];
  assign w32         = 32'(w);
  assign ram_idx     = w[RAM_AW-1:0];
  // Byte-offset bits and address bits above the decoded word index are ignored
  assign addr_unused = ^{bus.addr[inputAbits-1:Abits+2], bus.addr[1:0]};

  // Classify the word index into RAM, I/O window or unmapped gap
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    region = REGION_NONE;
    o      = '0;
    if (w32 < MEM_WORDS) begin
      region = REGION_RAM;
    end else if (w32 >= IO_BASE && w32 < IO_BASE + IO_WORDS) begin
      region = REGION_IO;
      o      = 4'(w32 - 32'(IO_BASE));
    end
  end

  assign io_wr     = bus.wr && (region == REGION_IO);
  assign kb_pop    = bus.rd && (region == REGION_IO) && (o == OFF_KB_DATA);
  assign ovf_clear = io_wr && (o == OFF_KB_STATUS) && bus.din[OVF_CLEAR_BIT];

  kb_fifo #(
    .DEPTH (KB_DEPTH),
    .W     (16)
  ) u_kb_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (kb_valid),
    .pop       (kb_pop),
    .din       (kb_char),
    .ovf_clear (ovf_clear),
    .head      (kb_head),
    .count     (kb_count),
    .full      (kb_full),
    .empty     (kb_empty),
    .overflow  (kb_ovf)
  );

  // Comes from the FIFO's registered count only, never from kb_valid
  assign kb_nonempty = !kb_empty;

  // RAM write, one lane per enabled byte
  always_ff @(posedge clock) begin
    if (bus.wr && region == REGION_RAM) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (bus.be[k]) ram[ram_idx][8*k +: 8] <= bus.din[8*k +: 8];
      end
    end
  end

  // Output registers take full-word writes; byte enables do not apply to I/O
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_regs <= '0;
    end else begin
      for (int i = 0; i < NOUT; i++) begin
        if (io_wr && o == OFF_OUT_BASE + 4'(i)) out_regs[i*Dbits +: Dbits] <= bus.din;
      end
    end
  end

  // Free-running cycle counter, read-only from the bus
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cycles <= '0;
    else          cycles <= cycles + Dbits'(1);
  end

  // Assemble the KB_STATUS word
  always_comb begin
    status                          = '0;
    status[STAT_NONEMPTY]           = !kb_empty;
    status[STAT_FULL]               = kb_full;
    status[STAT_OVERFLOW]           = kb_ovf;
    status[STAT_COUNT_LSB +: CW]    = kb_count;
  end

  // Combinational read mux over RAM, I/O registers and the unmapped gap
  always_comb begin
    rdata = '0;
    case (region)
      REGION_RAM: rdata = ram[ram_idx];
      REGION_IO: begin
        case (o)
          OFF_KB_DATA:   if (!kb_empty) rdata = Dbits'(kb_head);
          OFF_KB_STATUS: rdata = status;
          OFF_CYCLES:    rdata = cycles;
          default: begin
            for (int i = 0; i < NOUT; i++) begin
              if (o == OFF_OUT_BASE + 4'(i)) rdata = out_regs[i*Dbits +: Dbits];
            end
          end
        endcase
      end
      default: rdata = '0;
    endcase
  end

  assign bus.dout = rdata;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio. A behavioural model (word array, key
// queue, plain counters) is updated on every rising edge; a compare process
// checks dout, kb_nonempty and out_regs against it on every falling edge.
// Directed steps add literal expectations that pin the model, then a
// randomized phase exercises the whole address map.
module tb_dmem_mmio;

  localparam int MEM_WORDS = 1616;
  localparam int IO_BASE   = 4080;
  localparam int KB_DEPTH  = 8;
  localparam int NOUT      = 2;

  localparam logic [31:0] A_KBD  = 32'(IO_BASE * 4);
  localparam logic [31:0] A_STAT = A_KBD + 32'd4;
  localparam logic [31:0] A_OUT0 = A_KBD + 32'd8;
  localparam logic [31:0] A_OUT1 = A_KBD + 32'd12;
  localparam logic [31:0] A_CYC  = A_KBD + 32'd60;
  localparam logic [31:0] A_GAP  = 32'd2000 * 32'd4;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        kb_valid = 1'b0;
  logic [15:0] kb_char  = '0;
  logic        kb_nonempty;
  logic [NOUT*32-1:0] out_regs;

  dmem_mmio_if #(.inputAbits(32), .Dbits(32)) bus ();

  dmem_mmio #(
    .inputAbits (32),
    .Abits      (12),
    .Dbits      (32),
    .MEM_WORDS  (MEM_WORDS),
    .IO_BASE    (IO_BASE),
    .KB_DEPTH   (KB_DEPTH),
    .NOUT       (NOUT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .kb_valid    (kb_valid),
    .kb_char     (kb_char),
    .kb_nonempty (kb_nonempty),
    .out_regs    (out_regs)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram   [MEM_WORDS];
  logic [3:0]  m_known [MEM_WORDS];
  logic [15:0] m_q [$];
  bit          m_ovf;
  logic [31:0] m_out [NOUT];
  logic [31:0] m_cyc;

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < NOUT; i++) m_out[i] = '0;
    m_cyc = '0;
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd4096);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    int o;
    w = word_of(a);
    if (w < MEM_WORDS) return m_ram[w];
    if (w >= IO_BASE) begin
      o = w - IO_BASE;
      if (o == 0)  return (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0;
      if (o == 1)  return (32'(m_q.size()) << 8) | (32'(m_ovf) << 2)
                        | (32'(m_q.size() == KB_DEPTH) << 1) | 32'(m_q.size() != 0);
      if (o >= 2 && o < 2 + NOUT) return m_out[o-2];
      if (o == 15) return m_cyc;
    end
    return 32'd0;
  endfunction

  // Only RAM bytes the bench has written carry a defined value
  function automatic logic [31:0] model_mask(input logic [31:0] a);
    int w;
    logic [31:0] m;
    w = word_of(a);
    if (w >= MEM_WORDS) return 32'hFFFF_FFFF;
    m = '0;
    for (int b = 0; b < 4; b++) if (m_known[w][b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  int  mw;
  int  mo;
  bit  m_pop;
  bit  m_drop;

  // Advance the model by one clock using the pre-edge inputs
  always @(posedge clock) begin
    if (reset_n) begin
      mw     = word_of(bus.addr);
      mo     = mw - IO_BASE;
      m_pop  = bus.rd && mw >= IO_BASE && mo == 0 && m_q.size() > 0;
      m_drop = 1'b0;
      if (bus.wr && mw < MEM_WORDS) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.be[b]) begin
            m_ram[mw][8*b +: 8] = bus.din[8*b +: 8];
            m_known[mw][b]      = 1'b1;
          end
        end
      end
      if (bus.wr && mw >= IO_BASE && mo >= 2 && mo < 2 + NOUT) m_out[mo-2] = bus.din;
      if (m_pop) void'(m_q.pop_front());
      if (kb_valid) begin
        if (m_q.size() < KB_DEPTH) m_q.push_back(kb_char);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (bus.wr && mw >= IO_BASE && mo == 1 && bus.din[2]) m_ovf = 1'b0;
      m_cyc = m_cyc + 32'd1;
    end
  end

  // Compare DUT outputs with the model every falling edge
  always @(negedge clock) begin
    logic [31:0] msk;
    msk = model_mask(bus.addr);
    if (msk != 32'd0) check("dout", 64'(bus.dout & msk), 64'(model_read(bus.addr) & msk));
    check("kb_nonempty", 64'(kb_nonempty), 64'(m_q.size() != 0));
    check("out_regs", 64'(out_regs), 64'({m_out[1], m_out[0]}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic w, input logic r, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic kv, input logic [15:0] kc);
    bus.wr   = w;
    bus.rd   = r;
    bus.be   = b;
    bus.addr = a;
    bus.din  = d;
    kb_valid = kv;
    kb_char  = kc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic access_check(input logic w, input logic r, input logic [3:0] b, input logic [31:0] a,
                              input logic [31:0] d, input logic kv, input logic [15:0] kc,
                              input string name, input logic [31:0] exp);
    drive(w, r, b, a, d, kv, kc);
    @(negedge clock);
    check(name, 64'(bus.dout), 64'(exp));
    tick();
  endtask

  task automatic peek(input logic [31:0] a, input string name, input logic [31:0] exp);
    access_check(1'b0, 1'b0, 4'h0, a, 32'd0, 1'b0, 16'd0, name, exp);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    access_check(1'b0, 1'b1, 4'h0, A_KBD, 32'd0, 1'b0, 16'd0, name, exp);
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b0, b, a, d, 1'b0, 16'd0);
    tick();
  endtask

  task automatic push(input logic [15:0] c);
    drive(1'b0, 1'b0, 4'h0, A_GAP, 32'd0, 1'b1, c);
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) m_known[i] = 4'h0;
    model_reset();
    drive(1'b0, 1'b0, 4'h0, A_GAP, 32'd0, 1'b0, 16'd0);
    repeat (2) @(posedge clock);
    #1;
    peek(A_STAT, "reset_status", 32'd0);
    peek(A_CYC, "reset_cycles", 32'd0);
    reset_n = 1'b1;

    // RAM byte enables and the unmapped gap
    write(32'h10, 32'hDEAD_BEEF, 4'hF);
    write(32'h10, 32'h0000_AB00, 4'h2);
    peek(32'h10, "ram_be_merge", 32'hDEAD_ABEF);
    peek(A_GAP, "gap_read", 32'd0);

    // Basic FIFO order and non-popping read
    push(16'h0041);
    push(16'h0042);
    peek(A_STAT, "status_two", 32'h0000_0201);
    peek(A_KBD, "kbd_no_pop", 32'h41);
    pop_check("kbd_pop1", 32'h41);
    pop_check("kbd_pop2", 32'h42);
    peek(A_STAT, "status_empty", 32'd0);
    pop_check("kbd_empty_read", 32'd0);

    // Overflow: nine keys into eight slots
    for (int i = 0; i < 9; i++) push(16'(16'h0100 + i));
    peek(A_STAT, "status_overflow", 32'h0000_0807);
    write(A_STAT, 32'h0000_0004, 4'h0);
    peek(A_STAT, "status_ovf_clear", 32'h0000_0803);

    // Full FIFO: pop and push in the same cycle
    access_check(1'b0, 1'b1, 4'h0, A_KBD, 32'd0, 1'b1, 16'h0AAA, "full_pop_push", 32'h100);
    peek(A_STAT, "status_full_swap", 32'h0000_0803);
    for (int i = 1; i < 8; i++) pop_check("drain", 32'(32'h100 + i));
    pop_check("drain_new_last", 32'h0AAA);

    // Empty FIFO: read and push in the same cycle
    access_check(1'b0, 1'b1, 4'h0, A_KBD, 32'd0, 1'b1, 16'h0BBB, "empty_push_read", 32'd0);
    peek(A_STAT, "status_one", 32'h0000_0101);

    // Output register and asynchronous reset
    write(A_OUT1, 32'h1234_5678, 4'h0);
    drive(1'b0, 1'b0, 4'h0, A_OUT1, 32'd0, 1'b0, 16'd0);
    @(negedge clock);
    check("out1_bits", 64'(out_regs[63:32]), 64'h1234_5678);
    check("out1_read", 64'(bus.dout), 64'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 4'h0, A_STAT, 32'd0, 1'b0, 16'd0);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_regs", 64'(out_regs), 64'd0);
    check("rst_status", 64'(bus.dout), 64'd0);
    check("rst_nonempty", 64'(kb_nonempty), 64'd0);
    bus.addr = A_CYC;
    #1;
    check("rst_cycles", 64'(bus.dout), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Cycle counter
    repeat (100) @(posedge clock);
    #1;
    access_check(1'b1, 1'b0, 4'hF, A_CYC, 32'hFFFF_FFFF, 1'b0, 16'd0, "cycles_100", 32'd100);
    peek(A_CYC, "cycles_after_write", 32'd101);

    // Randomized traffic over RAM pool, I/O window and gap
    for (int k = 0; k < 8; k++) write(32'(k * 4), $urandom, 4'hF);
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)       a = 32'($urandom_range(0, 7) * 4);
      else if (sel < 6)  a = A_KBD;
      else if (sel < 9)  a = A_KBD + 32'($urandom_range(0, 15) * 4);
      else               a = A_GAP;
      drive(($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), a, $urandom,
            ($urandom_range(0, 2) == 0), 16'($urandom));
      tick();
    end

    drive(1'b0, 1'b0, 4'h0, A_GAP, 32'd0, 1'b0, 16'd0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Parametrised successor to the processor data memory: word-addressed RAM with byte-enable writes and combinational read, plus a 16-word memory-mapped I/O window. The window holds a keyboard FIFO that pops on read, a status register, NOUT general output registers and a free-running cycle counter. It sits on the single-cycle processor's data port between the ALU address and the writeback mux, fed by the keyboard decoder.

Parameters:
inputAbits, 32, width of processor byte address
Abits, 12, word-address bits used (word index = addr[Abits+1:2])
Dbits, 32, data width; must be a multiple of 8
MEM_WORDS, 1616, RAM depth in words; must be <= IO_BASE
IO_BASE, 4080, word index of first I/O word; the window is IO_BASE..IO_BASE+15
KB_DEPTH, 8, keyboard FIFO depth; power of 2, >= 2
NOUT, 2, number of output registers, 1..8

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
wr  in  1  write enable for this cycle
rd  in  1  read strobe; qualifies side-effect reads (FIFO pop)
be  in  Dbits/8  byte enables for RAM writes
addr  in  inputAbits  byte address; addr[1:0] ignored
din  in  Dbits  write data
dout  out  Dbits  read data, combinational from addr
kb_valid  in  1  one-cycle strobe: kb_char is a new key
kb_char  in  16  key code
kb_nonempty  out  1  FIFO holds at least one entry
out_regs  out  NOUT*Dbits  output register i on bits [i*Dbits +: Dbits]

Behaviour:
- Decode on w = addr[Abits+1:2]. If w < MEM_WORDS: RAM. If IO_BASE <= w <= IO_BASE+15: I/O with offset o = w-IO_BASE. Any other w: read 0, writes ignored.
- RAM: write on the rising edge when wr is high; byte k is written only if be[k]. Read is combinational (zero latency). Contents are not reset and are X after power-up.
- o=0 KB_DATA: read returns {zero-ext, head} when non-empty, 0 when empty. A pop occurs at the edge only when rd && o==0 && !empty. Writes are ignored.
- o=1 KB_STATUS: read returns bit0 non-empty, bit1 full, bit2 overflow (sticky), bits[8+:log2(KB_DEPTH)+1] count, all other bits 0. A write with din[2]=1 clears overflow; other bits are read-only.
- o=2..2+NOUT-1 OUT[i]: read/write full word; be is ignored for all I/O writes. Reset value 0.
- o=15 CYCLES: read-only counter. Reset 0, +1 every clock, wraps modulo 2^Dbits.
- Other offsets read 0; writes are ignored.
- FIFO push: at the edge when kb_valid is high.
  - If not full: push.
  - If full with no pop in the same cycle: drop the key and set overflow.
  - If full and a pop occurs in the same cycle: both happen, count unchanged, no overflow.
  - If empty with a simultaneous push and a KB_DATA read: the read returns 0, no pop, push proceeds, count becomes 1.
- Overflow: setting has priority over a clear in the same cycle.
- Pointers wrap modulo KB_DEPTH. Count ranges 0..KB_DEPTH.
- kb_nonempty = (count != 0), registered-state derived, with no combinational path from kb_valid.
- Reset (async, any time): FIFO pointers, count, overflow, OUT regs and CYCLES go to 0 immediately. kb_nonempty=0. dout reflects the reset state combinationally. A push or pop in flight at reset is lost.
- wr && rd on the same address are legal. The read sees the pre-edge value.

Decomposition:
- Package dmem_mmio_pkg holds: the I/O offset constants (KB_DATA=0, KB_STATUS=1, OUT_BASE=2, CYCLES=15), the status bit positions, and the overflow-clear bit.
- One sub-module, kb_fifo: parametrised KB_DEPTH x 16 FIFO with push, pop, head, count, full, empty and sticky overflow/clear.
- RAM, decode, OUT regs and counter stay in dmem_mmio.

Test Plan:
- Reset, then write 0xDEADBEEF to byte addr 0x10 with be=1111, then write be=0010 din=0x0000AB00 -> read of 0x10 returns 0xDEADABEF. Read of a word in the gap MEM_WORDS..IO_BASE-1 returns 0.
- Push keys 0x0041, 0x0042. STATUS reads count=2, bit0=1. Two KB_DATA reads with rd=1 -> 0x41 then 0x42. Then STATUS bit0=0 and a third read returns 0. A KB_DATA read with rd=0 does not pop.
- Push 9 keys with KB_DEPTH=8 -> count=8, full=1, overflow=1, and the 9th key is lost. Write STATUS din[2]=1 -> overflow=0.
- With the FIFO full, pop and kb_valid in the same cycle -> count stays 8, overflow stays 0, and the new key is read last. With the FIFO empty, push and read in the same cycle -> read returns 0, count=1.
- Write OUT[1]=0x12345678 -> out_regs[63:32]=0x12345678. Assert reset_n low mid-cycle -> out_regs=0, count=0 and CYCLES=0 without waiting for a clock edge.
- Release reset and run 100 clocks -> CYCLES reads 100. A write to CYCLES leaves it unchanged.
